// File: rtl/data_mem_unit.sv
// Data RAM plus MMIO window (timer with compare IRQ, optional UART TX).
// Optional UART transmitter enabled by defining DATA_MEM_UART_EN.
module data_mem_unit #(
   parameter int          DEPTH        = 1024,
   parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
   parameter int          CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_mem_write,
   input  logic [1:0]  i_size,
   output logic [31:0] o_rdata,
   output logic        o_misaligned,
   output logic        o_timer_irq,
   output logic        o_uart_tx
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem [DEPTH];
   logic        is_ram, is_mmio, ram_we, mmio_we;
   logic [3:0]  be;
   logic [31:0] wdata_sh;
   logic [1:0]  reg_sel;
   logic [31:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
   logic        irq_q;
   logic [31:0] stat_rd;

   assign is_ram   = (i_addr >> 2) < 32'(DEPTH);
   assign is_mmio  = i_addr[31:4] == MMIO_BASE[31:4];
   assign reg_sel  = i_addr[3:2];
   assign wdata_sh = i_wdata << {i_addr[1:0], 3'b000};

   always_comb begin
      o_misaligned = 1'b0;
      be           = 4'b1111;
      unique case (i_size)
         2'b00: be = 4'b0001 << i_addr[1:0];
         2'b01: begin
            be           = 4'b0011 << i_addr[1:0];
            o_misaligned = i_addr[0];
         end
         default: o_misaligned = |i_addr[1:0];
      endcase
   end

   assign ram_we  = i_mem_write & is_ram & ~o_misaligned;
   // MMIO registers only accept aligned full-word stores
   assign mmio_we = i_mem_write & is_mmio & i_size[1] & ~o_misaligned;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[i_addr[AW+1:2]][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   always_comb begin
      mtime_d    = mtime_q + 32'd1;
      mtimecmp_d = mtimecmp_q;
      if (mmio_we && reg_sel == 2'd0) mtime_d = i_wdata;
      if (mmio_we && reg_sel == 2'd1) mtimecmp_d = i_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         irq_q      <= mtime_q >= mtimecmp_q;
      end
   end

   assign o_timer_irq = irq_q;

`ifdef DATA_MEM_UART_EN
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_e;

   uart_st_e      st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          ovr_q, ovr_d;
   logic          busy, tx_wr, stat_wr;

   assign busy    = st_q != IDLE;
   assign tx_wr   = mmio_we && reg_sel == 2'd2;
   assign stat_wr = mmio_we && reg_sel == 2'd3;

   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      ovr_d     = ovr_q;
      o_uart_tx = 1'b1;
      if (stat_wr && i_wdata[1]) ovr_d = 1'b0;
      if (tx_wr && busy) ovr_d = 1'b1;
      unique case (st_q)
         IDLE: begin
            if (tx_wr) begin
               st_d  = START;
               cnt_d = '0;
               sh_d  = i_wdata[7:0];
            end
         end
         START: begin
            o_uart_tx = 1'b0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               st_d  = DATA;
               cnt_d = '0;
               bit_d = '0;
            end
         end
         DATA: begin
            o_uart_tx = sh_q[0];
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               sh_d  = sh_q >> 1;
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) st_d = STOP;
            end
         end
         STOP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               st_d  = IDLE;
               cnt_d = '0;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q  <= IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         sh_q  <= '0;
         ovr_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         sh_q  <= sh_d;
         ovr_q <= ovr_d;
      end
   end

   assign stat_rd = {30'd0, ovr_q, busy};
`else
   assign o_uart_tx = 1'b1;
   assign stat_rd   = '0;
`endif

   always_comb begin
      o_rdata = '0;
      if (is_ram) begin
         o_rdata = mem[i_addr[AW+1:2]];
      end else if (is_mmio) begin
         unique case (reg_sel)
            2'd0: o_rdata = mtime_q;
            2'd1: o_rdata = mtimecmp_q;
            2'd2: o_rdata = '0;
            2'd3: o_rdata = stat_rd;
            default: o_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: RAM lanes, misalignment, timer, UART.
// UART frame checks run only when DATA_MEM_UART_EN is defined.
module tb_data_mem_unit;

   localparam logic [31:0] MTIME = 32'h8000_0000;
   localparam logic [31:0] MCMP  = 32'h8000_0004;
   localparam logic [31:0] TXR   = 32'h8000_0008;
   localparam logic [31:0] STAT  = 32'h8000_000C;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_addr, i_wdata, o_rdata;
   logic        i_mem_write;
   logic [1:0]  i_size;
   logic        o_misaligned, o_timer_irq, o_uart_tx;
   int          errors = 0;
   int          checks = 0;

   data_mem_unit #(.DEPTH(1024), .MMIO_BASE(32'h8000_0000),
                   .CLKS_PER_BIT(4)) dut (
      .clk(clk), .reset(reset), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_mem_write(i_mem_write), .i_size(i_size), .o_rdata(o_rdata),
      .o_misaligned(o_misaligned), .o_timer_irq(o_timer_irq),
      .o_uart_tx(o_uart_tx));

   always #5 clk = ~clk;

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s);
      i_addr = a; i_wdata = d; i_size = s; i_mem_write = 1'b1;
      @(posedge clk); #1;
      i_mem_write = 1'b0;
      i_size = 2'b10;
   endtask

   task automatic test_reset;
      reset = 1'b1; i_mem_write = 1'b0; i_addr = '0;
      i_wdata = '0; i_size = 2'b10;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      i_addr = MTIME; #1;
      checks++;
      if (o_rdata !== 32'd0) begin
         errors++; $display("FAIL reset_mtime got=%h exp=%h", o_rdata, 32'd0);
      end
      i_addr = MCMP; #1;
      checks++;
      if (o_rdata !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL reset_mtimecmp got=%h exp=FFFFFFFF", o_rdata);
      end
      i_addr = STAT; #1;
      checks++;
      if (o_rdata !== 32'd0) begin
         errors++; $display("FAIL reset_stat got=%h exp=0", o_rdata);
      end
      checks++;
      if (o_timer_irq !== 1'b0 || o_uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_outs got irq=%b tx=%b exp irq=0 tx=1",
                  o_timer_irq, o_uart_tx);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ram;
      wr(32'h10, 32'hDEAD_BEEF, 2'b10);
      wr(32'h11, 32'hFFFF_FF55, 2'b00);
      i_addr = 32'h10; #1;
      checks++;
      if (o_rdata !== 32'hDEAD_55EF) begin
         errors++; $display("FAIL sb_lane1 got=%h exp=DEAD55EF", o_rdata);
      end
      wr(32'h20, 32'h1122_3344, 2'b10);
      wr(32'h22, 32'hFFFF_ABCD, 2'b01);
      wr(32'h23, 32'h0000_0077, 2'b00);
      i_addr = 32'h20; #1;
      checks++;
      if (o_rdata !== 32'h77CD_3344) begin
         errors++; $display("FAIL sh_sb_upper got=%h exp=77CD3344", o_rdata);
      end
      wr(32'h0, 32'h0BAD_F00D, 2'b10);
      wr(32'hFFC, 32'hCAFE_0001, 2'b10);
      wr(32'h1000, 32'h1234_5678, 2'b10);
      i_addr = 32'hFFC; #1;
      checks++;
      if (o_rdata !== 32'hCAFE_0001) begin
         errors++; $display("FAIL last_word got=%h exp=CAFE0001", o_rdata);
      end
      i_addr = 32'h0; #1;
      checks++;
      if (o_rdata !== 32'h0BAD_F00D) begin
         errors++; $display("FAIL no_alias got=%h exp=0BADF00D", o_rdata);
      end
      i_addr = 32'h1000; #1;
      checks++;
      if (o_rdata !== 32'd0) begin
         errors++; $display("FAIL unmapped_1000 got=%h exp=0", o_rdata);
      end
   endtask

   task automatic test_misaligned;
      i_addr = 32'h13; i_wdata = 32'h1234; i_size = 2'b01;
      i_mem_write = 1'b1; #1;
      checks++;
      if (o_misaligned !== 1'b1) begin
         errors++; $display("FAIL mis_half got=%b exp=1", o_misaligned);
      end
      @(posedge clk); #1;
      i_mem_write = 1'b0;
      i_addr = 32'h12; #1;
      checks++;
      if (o_misaligned !== 1'b0) begin
         errors++; $display("FAIL aligned_half got=%b exp=0", o_misaligned);
      end
      i_size = 2'b10; i_addr = 32'h10; #1;
      checks++;
      if (o_rdata !== 32'hDEAD_55EF) begin
         errors++; $display("FAIL mis_no_write got=%h exp=DEAD55EF", o_rdata);
      end
      wr(32'h14, 32'h5555_AAAA, 2'b10);
      i_addr = 32'h16; i_wdata = 32'hFFFF_FFFF; i_mem_write = 1'b1; #1;
      checks++;
      if (o_misaligned !== 1'b1) begin
         errors++; $display("FAIL mis_word got=%b exp=1", o_misaligned);
      end
      @(posedge clk); #1;
      i_mem_write = 1'b0;
      i_addr = 32'h14; #1;
      checks++;
      if (o_rdata !== 32'h5555_AAAA) begin
         errors++; $display("FAIL mis_word_kept got=%h exp=5555AAAA", o_rdata);
      end
   endtask

   task automatic test_timer;
      wr(MCMP, 32'h0000_00FF, 2'b00);
      i_addr = MCMP; #1;
      checks++;
      if (o_rdata !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL mmio_subword got=%h exp=FFFFFFFF", o_rdata);
      end
      wr(MTIME, 32'd0, 2'b10);
      wr(MCMP, 32'd20, 2'b10);
      wr(MTIME, 32'd0, 2'b10);
      i_addr = MTIME;
      for (int c = 0; c <= 23; c++) begin
         #1;
         if (c == 0 || c == 20) begin
            checks++;
            if (o_rdata !== 32'(c)) begin
               errors++;
               $display("FAIL mtime_c%0d got=%h exp=%h", c, o_rdata, 32'(c));
            end
         end
         if (c == 20 || c == 21 || c == 23) begin
            checks++;
            if (o_timer_irq !== (c >= 21)) begin
               errors++;
               $display("FAIL irq_c%0d got=%b exp=%b", c, o_timer_irq, c >= 21);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wrap;
      logic [31:0] exp [3];
      exp[0] = 32'hFFFF_FFFE; exp[1] = 32'hFFFF_FFFF; exp[2] = 32'd0;
      wr(MTIME, 32'hFFFF_FFFE, 2'b10);
      i_addr = MTIME;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (o_rdata !== exp[k]) begin
            errors++; $display("FAIL wrap_%0d got=%h exp=%h", k, o_rdata, exp[k]);
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef DATA_MEM_UART_EN
   task automatic test_uart;
      logic [9:0] frame;
      frame = {1'b1, 8'hA5, 1'b0};
      wr(TXR, 32'h0000_00A5, 2'b10);
      for (int i = 0; i < 40; i++) begin
         i_addr = STAT; i_mem_write = 1'b0; #1;
         checks++;
         if (o_uart_tx !== frame[i/4] || o_rdata[0] !== 1'b1) begin
            errors++;
            $display("FAIL uart_bit%0d got tx=%b busy=%b exp tx=%b busy=1",
                     i, o_uart_tx, o_rdata[0], frame[i/4]);
         end
         if (i == 20) begin
            i_addr = TXR; i_wdata = 32'h3C; i_mem_write = 1'b1;
         end
         @(posedge clk); #1;
      end
      i_addr = STAT; i_mem_write = 1'b0; #1;
      checks++;
      if (o_rdata !== 32'd2 || o_uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL uart_done got stat=%h tx=%b exp stat=2 tx=1",
                  o_rdata, o_uart_tx);
      end
      wr(STAT, 32'd2, 2'b10);
      i_addr = STAT; #1;
      checks++;
      if (o_rdata !== 32'd0) begin
         errors++; $display("FAIL ovr_clear got=%h exp=0", o_rdata);
      end
   endtask
`else
   task automatic test_uart;
      wr(TXR, 32'h0000_00A5, 2'b10);
      for (int i = 0; i < 3; i++) begin
         i_addr = STAT; #1;
         checks++;
         if (o_rdata !== 32'd0 || o_uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL uart_off%0d got stat=%h tx=%b exp stat=0 tx=1",
                     i, o_rdata, o_uart_tx);
         end
         @(posedge clk); #1;
      end
   endtask
`endif

   task automatic test_reset_mid;
`ifdef DATA_MEM_UART_EN
      wr(TXR, 32'h0000_00FE, 2'b10);
      repeat (9) @(posedge clk);
      #1;
`endif
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      i_addr = STAT; #1;
      checks++;
      if (o_uart_tx !== 1'b1 || o_rdata !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid got tx=%b stat=%h exp tx=1 stat=0",
                  o_uart_tx, o_rdata);
      end
      checks++;
      if (o_timer_irq !== 1'b0) begin
         errors++; $display("FAIL rst_irq got=%b exp=0", o_timer_irq);
      end
      i_addr = 32'h9000_0000; #1;
      checks++;
      if (o_rdata !== 32'd0) begin
         errors++; $display("FAIL unmapped_9000 got=%h exp=0", o_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_misaligned();
      test_timer();
      test_wrap();
      test_uart();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
